jk_bank_ctrl: RTL

- Command-driven controller that sequences a WIDTH-bit bank of JK flip-flops.
- It translates opcodes (hold, clear, set, toggle, load, count) into per-bit J/K drive and steps the bank through single-cycle or multi-cycle operations.
- It sits between a simple valid/ready command source and the JK register bank, which it instantiates internally.
- It reports completion and errors back to the command source.

---
 rtl/jk_ctrl_pkg.sv | 22 ++
 rtl/jk_cell.sv | 23 ++
 rtl/jk_bank_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - shared opcodes and state encoding for the JK bank controller
package jk_ctrl_pkg;

   localparam logic [2:0] OP_HOLD   = 3'd0;
   localparam logic [2:0] OP_CLEAR  = 3'd1;
   localparam logic [2:0] OP_SET    = 3'd2;
   localparam logic [2:0] OP_TOGGLE = 3'd3;
   localparam logic [2:0] OP_LOAD   = 3'd4;
   localparam logic [2:0] OP_COUNT  = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   function automatic logic op_is_illegal(input logic [2:0] op);
      return op > OP_COUNT;
   endfunction

endpackage

// File: rtl/jk_cell.sv
// rtl/jk_cell.sv - single JK flip-flop with asynchronous active-low clear
module jk_cell (
   input  logic clk,
   input  logic rst_n,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q <= 1'b0;
            2'b10:   q <= 1'b1;
            2'b11:   q <= ~q;
            default: q <= q;
         endcase
      end
   end

endmodule

// File: rtl/jk_bank_ctrl.sv
// rtl/jk_bank_ctrl.sv - command-driven sequencer for a bank of JK flip-flops
module jk_bank_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_len,
   output logic [WIDTH-1:0] q,
   output logic             busy,
   output logic             done,
   output logic             err
);

   state_t           state, state_nx;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] data_r;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] j, k;
   logic             carry;
   logic             accept;

   assign accept    = cmd_valid && cmd_ready;
   assign cmd_ready = (state == S_IDLE);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign err       = done && op_is_illegal(op_r);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_r   <= OP_HOLD;
         data_r <= '0;
         cnt    <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            op_r   <= cmd_op;
            data_r <= cmd_data;
            cnt    <= cmd_len;
         end else if (state == S_COUNT) begin
            cnt <= cnt - CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      j        = '0;
      k        = '0;
      carry    = 1'b1;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (cmd_op == OP_COUNT)
                  state_nx = (cmd_len != '0) ? S_COUNT : S_DONE;
               else
                  state_nx = S_EXEC;
            end
         end
         S_EXEC: begin
            case (op_r)
               OP_CLEAR:  k = '1;
               OP_SET:    j = '1;
               OP_TOGGLE: begin
                  j = '1;
                  k = '1;
               end
               OP_LOAD: begin
                  j = data_r;
                  k = ~data_r;
               end
               default: ;
            endcase
            state_nx = S_DONE;
         end
         S_COUNT: begin
            // ripple-enable synchronous up-counter: bit i toggles when all lower bits are 1
            for (int i = 0; i < WIDTH; i++) begin
               j[i]  = carry;
               k[i]  = carry;
               carry = carry & q[i];
            end
            if (cnt == CNT_W'(1))
               state_nx = S_DONE;
         end
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_cell
      jk_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .j     (j[g]),
         .k     (k[g]),
         .q     (q[g])
      );
   end

endmodule
